// File: rtl/even_parity_serial_tx_pkg.sv
// Shared definitions for the even-parity serial transmitter.
// Contents:
//   DEF_DATA_W   default payload width
//   FRAME_BITS   serial bits per frame: start + data + parity + stop
//   IDLE..STOP   3-bit FSM state encodings
//   parity_even  even-parity bit of a data word (same function the generator uses)
package even_parity_serial_tx_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int FRAME_BITS = DEF_DATA_W + 3;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // XOR-reduce: 1 when the word has an odd number of ones, so that
  // data plus parity always carries an even count.
  function automatic logic parity_even(input logic [DEF_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/even_parity_serial_tx_bit_timer.sv
// Bit-period timer for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and wraps at each bit boundary.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset
//   en    in   count while a frame is in progress
//   clr   in   restart the count (asserted on accept)
//   tick  out  high in the last cycle of each bit period
module even_parity_serial_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter.
// Accepts a parallel word over valid/ready, computes its even-parity bit and
// shifts out start(0), data LSB first, parity, stop(1). Each bit lasts
// CLKS_PER_BIT cycles. Outputs are decoded only from registers.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   tx_data    in   word to send, sampled only on accept
//   tx_valid   in   tx_data is valid
//   tx_ready   out  idle and able to accept
//   tx_serial  out  serial line, idles high
//   tx_busy    out  frame in progress
//   tx_done    out  one-cycle pulse in the last cycle of the stop bit
module even_parity_serial_tx
  import even_parity_serial_tx_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              parity_bit;
  logic              data_parity;
  logic              accept;
  logic              tick;

  assign accept = tx_valid && tx_ready;

  // The shared function is fixed at the package width; other widths fall
  // back to the equivalent reduction.
  generate
    if (DATA_W == DEF_DATA_W) begin : g_pkg_parity
      assign data_parity = parity_even(tx_data);
    end else begin : g_local_parity
      assign data_parity = ^tx_data;
    end
  endgenerate

  // Accept clears the timer so the start bit always gets a full period.
  even_parity_serial_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .clr (accept),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && (bit_cnt == LAST_BIT)) state_next = PARITY;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Data word and parity are captured once on accept; later changes on
  // tx_data are ignored. The shift register moves one bit per data period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else if (accept) begin
      shift_reg  <= tx_data;
      bit_cnt    <= '0;
      parity_bit <= data_parity;
    end else if ((state == DATA) && tick) begin
      shift_reg <= shift_reg >> 1;
      bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end
  end

  always_comb begin
    tx_serial = 1'b1;
    tx_busy   = (state != IDLE);
    tx_ready  = (state == IDLE);
    tx_done   = 1'b0;
    case (state)
      START:   tx_serial = 1'b0;
      DATA:    tx_serial = shift_reg[0];
      PARITY:  tx_serial = parity_bit;
      STOP:    tx_done   = tick;
      default: tx_serial = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Self-checking bench for even_parity_serial_tx with default parameters.
// Expected serial bits are queued when a word is offered and popped at the
// middle of each bit period as the frame is shifted out.
module tb_even_parity_serial_tx;
  import even_parity_serial_tx_pkg::*;

  localparam int CPB          = 4;
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int   tests_run    = 0;
  int   tests_failed = 0;
  logic exp_q[$];
  time  frame_start_t;

  even_parity_serial_tx #(
    .DATA_W      (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_serial(tx_serial),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("wait_ready", tx_ready, 1'b1);
  endtask

  // Offers a word at a falling edge; it is accepted on the following rising edge.
  task automatic apply_stimulus(input logic [7:0] d, input logic par, input logic hold);
    @(negedge clk);
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    push_frame(d, par);
    @(posedge clk);
    if (!hold) begin
      #1 tx_valid = 1'b0;
    end
  endtask

  // Walks cycles 0..FRAME_CYCLES after accept, checking line, handshake and done.
  task automatic check_frame(input string name, input int change_cycle, input logic [7:0] change_data);
    logic exp_bit;
    for (int c = 0; c <= FRAME_CYCLES; c++) begin
      @(negedge clk);
      if (c == 0) frame_start_t = $time;
      if (c == change_cycle) tx_data = change_data;
      if ((c < FRAME_CYCLES) && ((c % CPB) == CPB / 2)) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $error("[TB] FAIL %s scoreboard_empty observed=empty expected=bit", name);
        end else begin
          exp_bit = exp_q.pop_front();
          check_output($sformatf("%s serial_bit%0d", name, c / CPB), tx_serial, exp_bit);
        end
      end
      check_output($sformatf("%s ready_c%0d", name, c), tx_ready, 1'(c == FRAME_CYCLES));
      check_output($sformatf("%s busy_c%0d", name, c), tx_busy, 1'(c < FRAME_CYCLES));
      check_output($sformatf("%s done_c%0d", name, c), tx_done, 1'(c == FRAME_CYCLES - 1));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    time  t_first;
    logic seen_done;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #12;
    check_output("reset serial", tx_serial, 1'b1);
    check_output("reset ready", tx_ready, 1'b1);
    check_output("reset busy", tx_busy, 1'b0);
    check_output("reset done", tx_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_output("idle ready", tx_ready, 1'b1);
    check_output("idle serial", tx_serial, 1'b1);

    // Three ones: parity 1
    apply_stimulus(8'hA8, 1'b1, 1'b0);
    check_frame("t1_A8", -1, 8'h00);

    apply_stimulus(8'hF0, 1'b0, 1'b0);
    check_frame("t2_F0", -1, 8'h00);

    apply_stimulus(8'h00, 1'b0, 1'b0);
    check_frame("t3_00", -1, 8'h00);
    apply_stimulus(8'hFF, 1'b0, 1'b0);
    check_frame("t3_FF", -1, 8'h00);

    // Valid held high: the second word is taken the moment the block is idle again.
    apply_stimulus(8'h55, 1'b0, 1'b1);
    push_frame(8'h3C, 1'b0);
    #1 tx_data = 8'h3C;
    check_frame("t4_55", -1, 8'h00);
    t_first = frame_start_t;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check_frame("t4_3C", -1, 8'h00);
    tests_run++;
    assert ((frame_start_t - t_first) == 450) else begin
      tests_failed++;
      $error("[TB] FAIL t4_period observed=%0t expected=450", frame_start_t - t_first);
    end

    // Reset in cycle 20 abandons the frame.
    apply_stimulus(8'hA8, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_output("t5 serial_in_reset", tx_serial, 1'b1);
    check_output("t5 busy_in_reset", tx_busy, 1'b0);
    check_output("t5 done_in_reset", tx_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    seen_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx_done) seen_done = 1'b1;
    end
    check_output("t5 no_done_after_reset", seen_done, 1'b0);
    check_output("t5 ready_after_reset", tx_ready, 1'b1);
    apply_stimulus(8'hA8, 1'b1, 1'b0);
    check_frame("t5_after_reset", -1, 8'h00);

    // Input change mid-frame must not alter the word in flight.
    apply_stimulus(8'hA8, 1'b1, 1'b0);
    check_frame("t6_A8_change", 10, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
